// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_MDWAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: stage info in, hold/flush enables out.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] Ra_ID;
  logic [REG_W-1:0] Rb_ID;
  logic             UseA_ID;
  logic             UseB_ID;
  logic             MemWr_ID;
  logic             MemRd_EX;
  logic             RegWr_EX;
  logic [REG_W-1:0] Rd_EX;
  logic             BrTaken_EX;
  logic             MdStart_EX;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_flush;
  logic             exm_flush;
  logic             md_busy;

  // Pipeline side: drives stage info, consumes enables.
  modport master (
    output Ra_ID, Rb_ID, UseA_ID, UseB_ID, MemWr_ID,
    output MemRd_EX, RegWr_EX, Rd_EX, BrTaken_EX, MdStart_EX,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exm_flush, md_busy
  );

  // Controller side.
  modport slave (
    input  Ra_ID, Rb_ID, UseA_ID, UseB_ID, MemWr_ID,
    input  MemRd_EX, RegWr_EX, Rd_EX, BrTaken_EX, MdStart_EX,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exm_flush, md_busy
  );

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count enabled events until all-ones, then hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX branch flushes and
// multi-cycle mul/div occupancy of EX. Enables are combinational from
// state + inputs and forced low while rst_n is asserted.
// Optional macro PIPE_PERF_CNT_EN adds saturating perf counters
// (ldu_cnt, br_cnt, md_cnt_o).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ldu_cnt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] md_cnt_o
`endif
);

  localparam int unsigned MDC_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [MDC_W-1:0] MDC_LOAD = MDC_W'(MD_LAT - 2);

  state_e           r_state;
  logic [MDC_W-1:0] r_md_cnt;

  logic w_ldu;
  logic w_ldu_stall;
  logic w_br_flush;
  logic w_md_hold;

  // Load-use decode; a store matching only on Rb is left to store-data forwarding.
  assign w_ldu = hz.MemRd_EX && hz.RegWr_EX && (hz.Rd_EX != REG_ZERO) &&
                 ((hz.UseA_ID && (hz.Ra_ID == hz.Rd_EX)) ||
                  (hz.UseB_ID && (hz.Rb_ID == hz.Rd_EX) && !hz.MemWr_ID));

  // State and mul/div wait counter; the wait ends once the count would reach zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (hz.MdStart_EX) begin
            r_state  <= S_MDWAIT;
            r_md_cnt <= MDC_LOAD;
          end
        end
        S_MDWAIT: begin
          if (r_md_cnt <= MDC_W'(1)) begin
            r_state <= S_RUN;
          end
          if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MDC_W'(1);
          end
        end
        default: begin
          r_state  <= S_RUN;
          r_md_cnt <= '0;
        end
      endcase
    end
  end

  // Hazard priority: mul/div wait > branch flush > mul/div start > load-use stall.
  always_comb begin
    w_ldu_stall = 1'b0;
    w_br_flush  = 1'b0;
    w_md_hold   = 1'b0;
    if (rst_n) begin
      if (r_state == S_MDWAIT) begin
        w_md_hold = 1'b1;
      end else if (hz.BrTaken_EX) begin
        w_br_flush = 1'b1;
      end else if (hz.MdStart_EX) begin
        w_md_hold = 1'b1;
      end else if (w_ldu) begin
        w_ldu_stall = 1'b1;
      end
    end
  end

  // Map the selected hazard response onto the pipeline enables.
  always_comb begin
    hz.pc_hold    = w_md_hold | w_ldu_stall;
    hz.ifid_hold  = w_md_hold | w_ldu_stall;
    hz.ifid_flush = w_br_flush;
    hz.idex_hold  = w_md_hold;
    hz.idex_flush = w_br_flush | w_ldu_stall;
    hz.exm_flush  = w_md_hold;
    hz.md_busy    = w_md_hold;
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_sat_cnt #(.W(CNT_W)) u_ldu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_ldu_stall),
    .i_clr (1'b0),
    .o_cnt (ldu_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_br_flush),
    .i_clr (1'b0),
    .o_cnt (br_cnt)
  );

  pipe_sat_cnt #(.W(CNT_W)) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_md_hold),
    .i_clr (1'b0),
    .o_cnt (md_cnt_o)
  );
`endif

endmodule
